// File: rtl/mt9v034_vid_axis_pkg.sv
// mt9v034_vid_axis_pkg: state encoding and FIFO entry layout shared by the video-to-AXIS bridge
package mt9v034_vid_axis_pkg;
  typedef enum logic [1:0] {RESYNC, WAIT_SOF, ACTIVE} state_t;
  localparam int TLAST_OFS = 0;
  localparam int TUSER_OFS = 1;
  localparam int FLAG_BITS = 2;
endpackage

// File: rtl/vid_axis_sync_fifo.sv
// vid_axis_sync_fifo: first-word fall-through synchronous FIFO with full/empty flags
module vid_axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic do_wr, do_rd;
  assign empty = count == '0;
  assign full = count[ADDR_WIDTH];
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // storage array; contents are only meaningful behind the pointers, so no reset
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  // pointers and occupancy; a read in the same cycle frees the slot a full write needs
  always_ff @(posedge clk)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(do_wr);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(do_rd);
      count <= count + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
    end
endmodule

// File: rtl/mt9v034_vid_to_axis.sv
// mt9v034_vid_to_axis: MT9V034 pixel-clock video timing to AXI4-Stream video with overflow resync
module mt9v034_vid_to_axis
  import mt9v034_vid_axis_pkg::*;
#(
  parameter int VIDEO_BIT_WIDTH = 8,
  parameter int FIFO_ADDR_WIDTH = 5,
  parameter int LINE_CNT_WIDTH = 11
) (
  input  logic                       pxclk,
  input  logic                       resetn,
  input  logic                       pixel_data_valid,
  input  logic                       vid_active_video,
  input  logic                       vid_hblank,
  input  logic                       vid_vblank,
  input  logic [VIDEO_BIT_WIDTH-1:0] vid_data,
  input  logic                       receiver_locked,
  output logic [VIDEO_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [15:0]                frame_count,
  output logic [LINE_CNT_WIDTH-1:0]  line_width
);
  localparam int EW = VIDEO_BIT_WIDTH + FLAG_BITS;
  state_t state, state_nx;
  logic pixel, vblank_s, pop, ovf, wr_en, fifo_full, fifo_empty;
  logic go, load_first, load_next, push_end, end_frame;
  logic hold_v, hold_sof;
  logic [VIDEO_BIT_WIDTH-1:0] hold_d;
  logic push_v, push_eof;
  logic [EW-1:0] push_d, rd_data;
  logic [LINE_CNT_WIDTH-1:0] line_cnt;
  assign pixel = pixel_data_valid & vid_active_video & ~vid_hblank & ~vid_vblank;
  assign vblank_s = pixel_data_valid & vid_vblank;
  assign pop = m_axis_tvalid & m_axis_tready;
  assign ovf = push_v & fifo_full & ~pop;
  assign wr_en = push_v & ~ovf;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tuser = rd_data[VIDEO_BIT_WIDTH+TUSER_OFS];
  assign m_axis_tlast = rd_data[VIDEO_BIT_WIDTH+TLAST_OFS];
  assign m_axis_tdata = rd_data[VIDEO_BIT_WIDTH-1:0];
  // state register
  always_ff @(posedge pxclk)
    if (!resetn) state <= RESYNC;
    else state <= state_nx;
  // next state: lost lock or a dropped entry abandons the frame until the next vertical blank
  always_comb begin
    state_nx = state;
    if (!receiver_locked || ovf) state_nx = RESYNC;
    else if (state == RESYNC && vblank_s) state_nx = WAIT_SOF;
    else if (state == WAIT_SOF && pixel) state_nx = ACTIVE;
    else if (state == ACTIVE && vblank_s) state_nx = WAIT_SOF;
  end
  // output decode: what the current sample does to the hold register and the push stage
  always_comb begin
    go = receiver_locked & ~ovf;
    load_first = go & (state == WAIT_SOF) & pixel;
    load_next = go & (state == ACTIVE) & pixel;
    push_end = go & (state == ACTIVE) & pixel_data_valid & ~pixel & hold_v;
    end_frame = go & (state == ACTIVE) & vblank_s;
  end
  // one-pixel hold so the line's last pixel can be tagged, plus the registered push and line measurement
  always_ff @(posedge pxclk)
    if (!resetn) begin
      hold_v <= 1'b0;
      hold_sof <= 1'b0;
      hold_d <= '0;
      push_v <= 1'b0;
      push_eof <= 1'b0;
      push_d <= '0;
      line_cnt <= '0;
      line_width <= '0;
    end else begin
      push_v <= (load_next & hold_v) | push_end;
      push_d <= {hold_sof, push_end, hold_d};
      push_eof <= end_frame;
      if (load_first | load_next) begin
        hold_v <= 1'b1;
        hold_d <= vid_data;
        hold_sof <= load_first;
      end else if (push_end | ~go) hold_v <= 1'b0;
      if (load_first) line_cnt <= LINE_CNT_WIDTH'(1);
      else if (load_next) line_cnt <= &line_cnt ? line_cnt : line_cnt + 1'b1;
      else if (push_end) begin
        line_cnt <= '0;
        line_width <= line_cnt;
      end
    end
  // sticky overflow (set beats clear) and count of frames whose last push landed
  always_ff @(posedge pxclk)
    if (!resetn) begin
      overflow <= 1'b0;
      frame_count <= '0;
    end else begin
      overflow <= ovf | (overflow & ~overflow_clr);
      frame_count <= frame_count + 16'(push_eof & ~ovf);
    end
  vid_axis_sync_fifo #(.WIDTH(EW), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .clk(pxclk),
    .resetn(resetn),
    .wr_en(wr_en),
    .wr_data(push_d),
    .rd_en(pop),
    .rd_data(rd_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule
